axi_lite_arbiter: RTL and testbench
===================================

AXI_LITE_ARBITER -- requirements
Module: axi_lite_arbiter
Interface
REQ-001 PROT, 3'b000, value driven on AXI_arprot and AXI_awprot for every transaction.
REQ-002 AXI_CLK  in  1  single clock; all logic on rising edge.
REQ-003 RESET  in  1  synchronous, active-high reset.
REQ-004 REQ  in  2  per-requester request, bit n = requester n.
REQ-005 WE  in  2  1 = write, 0 = read, per requester.
REQ-006 ADDR  in  64  packed byte addresses, requester n at [32n+31:32n].
REQ-007 WDATA  in  64  packed write data, same packing.
REQ-008 WSTRB  in  8  packed byte strobes, requester n at [4n+3:4n].
REQ-009 ACK  out  2  one-cycle completion pulse to requester n.
REQ-010 RDATA  out  32  read data of last completed transaction, shared.
REQ-011 RESP  out  2  AXI response of last completed transaction, shared.
REQ-012 AXI_araddr  out  32  read address.
REQ-013 AXI_arprot  out  3  = PROT.
REQ-014 AXI_arvalid  out  1  read address valid.
REQ-015 AXI_arready  in  1  read address ready.
REQ-016 AXI_rdata  in  32  read data.
REQ-017 AXI_rresp  in  2  read response.
REQ-018 AXI_rvalid  in  1  read data valid.
REQ-019 AXI_rready  out  1  read data ready.
REQ-020 AXI_awaddr  out  32  write address.
REQ-021 AXI_awprot  out  3  = PROT.
REQ-022 AXI_awvalid  out  1  write address valid.
REQ-023 AXI_awready  in  1  write address ready.
REQ-024 AXI_wdata  out  32  write data.
REQ-025 AXI_wstrb  out  4  write strobes.
REQ-026 AXI_wvalid  out  1  write data valid.
REQ-027 AXI_wready  in  1  write data ready.
REQ-028 AXI_bresp  in  2  write response.
REQ-029 AXI_bvalid  in  1  write response valid.
REQ-030 AXI_bready  out  1  write response ready.
Function
REQ-031 The block SHALL allow one outstanding AXI transaction; states IDLE, AR, R, AW_W, B, RSP.
REQ-032 A requester SHALL hold REQ[n] with stable WE/ADDR/WDATA/WSTRB until ACK[n]; the block SHALL capture the granted requester's fields into registers on grant, and AXI address/data outputs SHALL come only from those registers.
REQ-033 In IDLE, the block SHALL grant round-robin: one request -> grant it; both -> grant the requester other than LAST; LAST updates on grant; the next state SHALL be AR (WE=0) or AW_W (WE=1); no request -> stay IDLE.
REQ-034 AR: arvalid=1 until arready; on arready, go to R with rready=1; on rvalid, capture rdata/rresp into RDATA/RESP and go to RSP.
REQ-035 AW_W: awvalid and wvalid SHALL assert in the same cycle, and each SHALL drop independently after its own ready (same or different cycles); when both are accepted, go to B with bready=1; on bvalid, capture bresp into RESP, set RDATA=0, and go to RSP.
REQ-036 RSP: ACK[granted]=1 for exactly one cycle, then go to IDLE; REQ is not arbitrated in RSP; REQ[n] still high in the following IDLE cycle SHALL be treated as a new request.
REQ-037 RDATA/RESP SHALL hold their values from ACK until the next completion; ACK bits SHALL never both be 1.
REQ-038 Minimum latency with all readies/valids immediate: REQ sampled in IDLE at cycle 0, AR/AW_W at cycle 1, R/B at cycle 2, ACK at cycle 3.
REQ-039 The block SHALL pass AXI_rresp/AXI_bresp unmodified and SHALL NOT retry on SLVERR/DECERR.
REQ-040 No valid or ready output SHALL be 1 in IDLE or RSP.
Reset
REQ-041 When RESET=1 at a clock edge: state=IDLE; all AXI valid/ready outputs=0; ACK=0; RDATA=0; RESP=0; LAST=1 (requester 0 wins the first tie); captured registers=0.
REQ-042 RESET mid-transaction SHALL abandon the transaction without ACK; requesters SHALL re-request.
Verification
REQ-043 Read: REQ=01, WE=0, ADDR0=0x1000, arready/rvalid immediate, rdata=0xDEADBEEF -> araddr=0x1000 at cycle 1, ACK=01 at cycle 3, RDATA=0xDEADBEEF, RESP=0.
REQ-044 Write: REQ=10, WE=10, ADDR1=0x2004, WDATA1=0x55, WSTRB1=0001; awready at cycle 1, wready at cycle 3, bvalid at cycle 5 -> awvalid low from cycle 2, wvalid low from cycle 4, ACK=10 once.
REQ-045 Contention: REQ=11 held continuously after reset -> grant order 0,1,0,1; ACK alternates 01,10.
REQ-046 Error: read with rresp=2'b10 -> RESP=2'b10 at ACK, no retry.
REQ-047 Reset: RESET asserted while in R -> next cycle all outputs at reset values; no ACK issued.

Source files
------------

// File: rtl/axi_lite_arbiter.sv
// Two-requester round-robin arbiter in front of a single AXI4-Lite master port.
// One transaction is outstanding at a time; the granted requester's fields are
// captured at grant and drive the AXI channels until completion.
module axi_lite_arbiter (
  input  logic        AXI_CLK,
  input  logic        RESET,
  input  logic [1:0]  REQ,
  input  logic [1:0]  WE,
  input  logic [63:0] ADDR,
  input  logic [63:0] WDATA,
  input  logic [7:0]  WSTRB,
  output logic [1:0]  ACK,
  output logic [31:0] RDATA,
  output logic [1:0]  RESP,
  output logic [31:0] AXI_araddr,
  output logic [2:0]  AXI_arprot,
  output logic        AXI_arvalid,
  input  logic        AXI_arready,
  input  logic [31:0] AXI_rdata,
  input  logic [1:0]  AXI_rresp,
  input  logic        AXI_rvalid,
  output logic        AXI_rready,
  output logic [31:0] AXI_awaddr,
  output logic [2:0]  AXI_awprot,
  output logic        AXI_awvalid,
  input  logic        AXI_awready,
  output logic [31:0] AXI_wdata,
  output logic [3:0]  AXI_wstrb,
  output logic        AXI_wvalid,
  input  logic        AXI_wready,
  input  logic [1:0]  AXI_bresp,
  input  logic        AXI_bvalid,
  output logic        AXI_bready
);

  localparam logic [2:0] PROT = 3'b000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_AW_W,
    S_B,
    S_RSP
  } state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic        gnt_q, gnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  resp_q, resp_d;

  logic        gnt_sel;
  logic        aw_acc;
  logic        w_acc;

  assign AXI_arprot = PROT;
  assign AXI_awprot = PROT;
  assign AXI_araddr = addr_q;
  assign AXI_awaddr = addr_q;
  assign AXI_wdata  = wdata_q;
  assign AXI_wstrb  = wstrb_q;
  assign RDATA      = rdata_q;
  assign RESP       = resp_q;

  // Next-state, capture and channel handshake outputs
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rdata_d     = rdata_q;
    resp_d      = resp_q;
    gnt_sel     = 1'b0;
    aw_acc      = 1'b0;
    w_acc       = 1'b0;
    ACK         = '0;
    AXI_arvalid = 1'b0;
    AXI_rready  = 1'b0;
    AXI_awvalid = 1'b0;
    AXI_wvalid  = 1'b0;
    AXI_bready  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (REQ != '0) begin
          // A lone request wins outright; a tie goes to the one not served last.
          gnt_sel   = (REQ == 2'b11) ? ~last_q : REQ[1];
          gnt_d     = gnt_sel;
          last_d    = gnt_sel;
          addr_d    = gnt_sel ? ADDR[63:32]  : ADDR[31:0];
          wdata_d   = gnt_sel ? WDATA[63:32] : WDATA[31:0];
          wstrb_d   = gnt_sel ? WSTRB[7:4]   : WSTRB[3:0];
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WE[gnt_sel] ? S_AW_W : S_AR;
        end
      end
      S_AR: begin
        AXI_arvalid = 1'b1;
        if (AXI_arready) state_d = S_R;
      end
      S_R: begin
        AXI_rready = 1'b1;
        if (AXI_rvalid) begin
          rdata_d = AXI_rdata;
          resp_d  = AXI_rresp;
          state_d = S_RSP;
        end
      end
      S_AW_W: begin
        // Address and data channels complete independently; the done flags
        // remember which one has already been accepted.
        AXI_awvalid = ~aw_done_q;
        AXI_wvalid  = ~w_done_q;
        aw_acc      = aw_done_q | AXI_awready;
        w_acc       = w_done_q  | AXI_wready;
        if (aw_acc && w_acc) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_B;
        end else begin
          aw_done_d = aw_acc;
          w_done_d  = w_acc;
        end
      end
      S_B: begin
        AXI_bready = 1'b1;
        if (AXI_bvalid) begin
          resp_d  = AXI_bresp;
          rdata_d = '0;
          state_d = S_RSP;
        end
      end
      S_RSP: begin
        ACK     = gnt_q ? 2'b10 : 2'b01;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and capture registers with synchronous reset
  always_ff @(posedge AXI_CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b1;
      gnt_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Bench for axi_lite_arbiter: directed scenarios followed by randomized
// requesters and a randomized AXI slave checked against a transaction model.
module tb_axi_lite_arbiter;

  logic        AXI_CLK = 1'b0;
  logic        RESET;
  logic [1:0]  REQ, WE;
  logic [63:0] ADDR, WDATA;
  logic [7:0]  WSTRB;
  logic [1:0]  ACK;
  logic [31:0] RDATA;
  logic [1:0]  RESP;
  logic [31:0] AXI_araddr, AXI_rdata, AXI_awaddr, AXI_wdata;
  logic [2:0]  AXI_arprot, AXI_awprot;
  logic        AXI_arvalid, AXI_arready, AXI_rvalid, AXI_rready;
  logic        AXI_awvalid, AXI_awready, AXI_wvalid, AXI_wready;
  logic        AXI_bvalid, AXI_bready;
  logic [1:0]  AXI_rresp, AXI_bresp;
  logic [3:0]  AXI_wstrb;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 AXI_CLK = ~AXI_CLK;

  axi_lite_arbiter dut (
    .AXI_CLK(AXI_CLK), .RESET(RESET), .REQ(REQ), .WE(WE), .ADDR(ADDR),
    .WDATA(WDATA), .WSTRB(WSTRB), .ACK(ACK), .RDATA(RDATA), .RESP(RESP),
    .AXI_araddr(AXI_araddr), .AXI_arprot(AXI_arprot), .AXI_arvalid(AXI_arvalid),
    .AXI_arready(AXI_arready), .AXI_rdata(AXI_rdata), .AXI_rresp(AXI_rresp),
    .AXI_rvalid(AXI_rvalid), .AXI_rready(AXI_rready), .AXI_awaddr(AXI_awaddr),
    .AXI_awprot(AXI_awprot), .AXI_awvalid(AXI_awvalid), .AXI_awready(AXI_awready),
    .AXI_wdata(AXI_wdata), .AXI_wstrb(AXI_wstrb), .AXI_wvalid(AXI_wvalid),
    .AXI_wready(AXI_wready), .AXI_bresp(AXI_bresp), .AXI_bvalid(AXI_bvalid),
    .AXI_bready(AXI_bready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: outputs are sampled and inputs changed on the falling edge.
  task automatic tick();
    @(posedge AXI_CLK);
    @(negedge AXI_CLK);
  endtask

  function automatic logic [4:0] valids();
    return {AXI_arvalid, AXI_rready, AXI_awvalid, AXI_wvalid, AXI_bready};
  endfunction

  task automatic zero_inputs();
    REQ = '0; WE = '0; ADDR = '0; WDATA = '0; WSTRB = '0;
    AXI_arready = 0; AXI_rdata = '0; AXI_rresp = '0; AXI_rvalid = 0;
    AXI_awready = 0; AXI_wready = 0; AXI_bresp = '0; AXI_bvalid = 0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    zero_inputs();
    tick();
    tick();
    RESET = 1'b0;
  endtask

  task automatic raise(input int n);
    REQ[n] = 1'b1;
    WE[n]  = 1'($urandom_range(0, 1));
    ADDR[n*32 +: 32]  = $urandom & 32'hFFFF_FFFC;
    WDATA[n*32 +: 32] = $urandom;
    WSTRB[n*4 +: 4]   = 4'($urandom_range(0, 15));
  endtask

  // Random-phase transaction model state
  logic        m_idle, exp_start, was_idle, ack_now, stop;
  logic        last_m, e_we;
  int          g_m, done, busy_cyc, cyc;
  logic [31:0] e_addr, e_wdata, e_rdata;
  logic [3:0]  e_wstrb;
  logic [1:0]  e_resp;
  logic        ar_hs, aw_hs, w_hs, resp_hs;

  initial begin
    RESET = 1'b1;
    zero_inputs();
    @(negedge AXI_CLK);

    // ---- reset state
    do_reset();
    chk("rst_valids", valids(), 5'b0);
    chk("rst_ack", ACK, 2'b00);
    chk("rst_rdata", RDATA, 32'h0);
    chk("rst_resp", RESP, 2'b00);
    chk("prot", {AXI_arprot, AXI_awprot}, 6'b0);

    // ---- basic read, immediate slave
    REQ = 2'b01; WE = 2'b00; ADDR[31:0] = 32'h1000;
    AXI_arready = 1; AXI_rvalid = 1; AXI_rdata = 32'hDEADBEEF; AXI_rresp = 2'b00;
    tick();
    chk("rd_c1_arvalid", AXI_arvalid, 1'b1);
    chk("rd_c1_araddr", AXI_araddr, 32'h1000);
    chk("rd_c1_ack", ACK, 2'b00);
    tick();
    chk("rd_c2_rready", {AXI_arvalid, AXI_rready}, 2'b01);
    tick();
    chk("rd_c3_ack", ACK, 2'b01);
    chk("rd_c3_rdata", RDATA, 32'hDEADBEEF);
    chk("rd_c3_resp", RESP, 2'b00);
    chk("rd_c3_valids", valids(), 5'b0);
    REQ = 2'b00; AXI_rvalid = 0; AXI_arready = 0;
    tick();
    chk("rd_c4_ack", ACK, 2'b00);
    chk("rd_c4_rdata_hold", RDATA, 32'hDEADBEEF);

    // ---- write with staggered ready/valid
    REQ = 2'b10; WE = 2'b10; ADDR[63:32] = 32'h2004; WDATA[63:32] = 32'h55; WSTRB[7:4] = 4'b0001;
    tick();
    chk("wr_c1_vld", {AXI_awvalid, AXI_wvalid}, 2'b11);
    chk("wr_c1_awaddr", AXI_awaddr, 32'h2004);
    chk("wr_c1_wdata", AXI_wdata, 32'h55);
    chk("wr_c1_wstrb", AXI_wstrb, 4'b0001);
    AXI_awready = 1;
    tick();
    chk("wr_c2_vld", {AXI_awvalid, AXI_wvalid}, 2'b01);
    AXI_awready = 0;
    tick();
    chk("wr_c3_vld", {AXI_awvalid, AXI_wvalid}, 2'b01);
    AXI_wready = 1;
    tick();
    chk("wr_c4_vld", {AXI_awvalid, AXI_wvalid, AXI_bready}, 3'b001);
    AXI_wready = 0;
    tick();
    chk("wr_c5_ack", ACK, 2'b00);
    AXI_bvalid = 1; AXI_bresp = 2'b00;
    tick();
    chk("wr_c6_ack", ACK, 2'b10);
    chk("wr_c6_rdata", RDATA, 32'h0);
    chk("wr_c6_resp", RESP, 2'b00);
    REQ = 2'b00; AXI_bvalid = 0;
    tick();
    chk("wr_c7_ack", ACK, 2'b00);

    // ---- contention after reset: grants alternate starting with requester 0
    do_reset();
    REQ = 2'b11; WE = 2'b00; ADDR = {32'h2000, 32'h1000};
    AXI_arready = 1; AXI_rvalid = 1; AXI_rdata = 32'hCAFE0000;
    for (int k = 0; k < 4; k++) begin
      int w;
      w = 0;
      do begin
        tick();
        w++;
      end while (ACK == 2'b00 && w < 10);
      chk("cont_ack", ACK, (k % 2 == 1) ? 2'b10 : 2'b01);
    end
    REQ = 2'b00;
    tick();

    // ---- error response passed through, no retry
    REQ = 2'b01; WE = 2'b00; ADDR[31:0] = 32'h4000;
    AXI_rdata = 32'h12345678; AXI_rresp = 2'b10;
    tick();
    tick();
    tick();
    chk("err_ack", ACK, 2'b01);
    chk("err_resp", RESP, 2'b10);
    chk("err_rdata", RDATA, 32'h12345678);
    REQ = 2'b00;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("err_no_retry", {valids(), ACK}, 7'b0);
    end

    // ---- reset while waiting for read data
    REQ = 2'b01; WE = 2'b00; ADDR[31:0] = 32'h3000;
    AXI_arready = 1; AXI_rvalid = 0;
    tick();
    tick();
    chk("rstR_in_r", AXI_rready, 1'b1);
    RESET = 1; REQ = 2'b00; AXI_rvalid = 1;
    tick();
    chk("rstR_valids", valids(), 5'b0);
    chk("rstR_ack", ACK, 2'b00);
    chk("rstR_rdata", RDATA, 32'h0);
    chk("rstR_resp", RESP, 2'b00);
    RESET = 0; AXI_rvalid = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rstR_no_ack", {valids(), ACK}, 7'b0);
    end

    // ---- randomized traffic against the transaction model
    do_reset();
    m_idle = 1; exp_start = 0; last_m = 1; stop = 0;
    done = 0; busy_cyc = 0; cyc = 0; g_m = 0;
    ar_hs = 0; aw_hs = 0; w_hs = 0; resp_hs = 0;
    e_we = 0; e_addr = '0; e_wdata = '0; e_wstrb = '0; e_rdata = '0; e_resp = '0;
    while (done < 40 && cyc < 8000 && !stop) begin
      tick();
      cyc++;
      was_idle = m_idle;
      ack_now  = 0;

      chk("rnd_ack_not_both", ACK == 2'b11, 1'b0);
      if (was_idle) begin
        chk("rnd_idle_valids", valids(), 5'b0);
        chk("rnd_idle_ack", ACK, 2'b00);
      end else begin
        busy_cyc++;
        if (exp_start) begin
          chk("rnd_start_dir", {AXI_arvalid, AXI_awvalid, AXI_wvalid}, e_we ? 3'b011 : 3'b100);
          chk("rnd_start_addr", e_we ? AXI_awaddr : AXI_araddr, e_addr);
          if (e_we) chk("rnd_start_wdata", {AXI_wstrb, AXI_wdata}, {e_wstrb, e_wdata});
          exp_start = 0;
        end
        if (aw_hs) chk("rnd_aw_drop", AXI_awvalid, 1'b0);
        if (w_hs)  chk("rnd_w_drop", AXI_wvalid, 1'b0);
        if (AXI_rready) chk("rnd_rready_after_ar", ar_hs, 1'b1);
        if (AXI_bready) chk("rnd_bready_after_aw_w", aw_hs && w_hs, 1'b1);
        if (ACK != 2'b00) begin
          chk("rnd_ack_who", ACK, (g_m == 1) ? 2'b10 : 2'b01);
          chk("rnd_ack_after_resp", resp_hs, 1'b1);
          chk("rnd_rdata", RDATA, e_rdata);
          chk("rnd_resp", RESP, e_resp);
          done++;
          ack_now = 1;
        end else if (busy_cyc > 200) begin
          chk("rnd_timeout", busy_cyc, 200);
          stop = 1;
        end
      end

      // slave side: decide what happens at the coming edge
      AXI_arready = 1'($urandom_range(0, 1));
      AXI_awready = 1'($urandom_range(0, 1));
      AXI_wready  = 1'($urandom_range(0, 1));
      if (AXI_arvalid && AXI_arready) ar_hs = 1;
      if (AXI_awvalid && AXI_awready) aw_hs = 1;
      if (AXI_wvalid && AXI_wready)   w_hs  = 1;
      AXI_rdata = $urandom;
      AXI_rresp = 2'($urandom_range(0, 3));
      AXI_rvalid = 0;
      if (AXI_rready && $urandom_range(0, 2) == 0) begin
        AXI_rvalid = 1;
        e_rdata = AXI_rdata;
        e_resp  = AXI_rresp;
        resp_hs = 1;
      end
      AXI_bresp = 2'($urandom_range(0, 3));
      AXI_bvalid = 0;
      if (AXI_bready && $urandom_range(0, 2) == 0) begin
        AXI_bvalid = 1;
        e_rdata = '0;
        e_resp  = AXI_bresp;
        resp_hs = 1;
      end

      // requester side: release on ACK, raise new work at random
      for (int n = 0; n < 2; n++) begin
        if (ACK[n]) begin
          REQ[n] = 1'b0;
          if ($urandom_range(0, 1) == 1) raise(n);
        end else if (!REQ[n] && $urandom_range(0, 3) == 0) begin
          raise(n);
        end
      end

      // arbitration happens only on an idle cycle, using what the edge will see
      if (was_idle && REQ != 2'b00) begin
        if (REQ == 2'b01)      g_m = 0;
        else if (REQ == 2'b10) g_m = 1;
        else if (last_m == 1'b1) g_m = 0;
        else                   g_m = 1;
        last_m    = (g_m == 1);
        e_we      = WE[g_m];
        e_addr    = ADDR[g_m*32 +: 32];
        e_wdata   = WDATA[g_m*32 +: 32];
        e_wstrb   = WSTRB[g_m*4 +: 4];
        exp_start = 1;
        m_idle    = 0;
        busy_cyc  = 0;
        ar_hs = 0; aw_hs = 0; w_hs = 0; resp_hs = 0;
      end
      if (ack_now) m_idle = 1;
    end
    if (!stop) chk("rnd_completions", done, 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
